// File: rtl/f8_run_supervisor.sv
// f8 run supervisor: reset sequencing, trap watch, cycle-budget timeout.
// Option F8_RUN_SUPERVISOR_GPIO_PASS_EN: gpio0pins signature ends the run with pass.
module f8_run_supervisor #(
  parameter int          CHANNELS       = 1,
  parameter int          RESET_CYCLES   = 5,
  parameter int          TIMEOUT_CYCLES = 2045,
  parameter int          TRAP_HOLDOFF   = 5,
  parameter logic [7:0]  PASS_CODE      = 8'ha5,
  parameter int          PASS_STABLE    = 4,
  localparam int         CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int         CCW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                power_on_reset_n,
  input  logic [CHANNELS-1:0] trap,
  input  logic [7:0]          gpio0pins,
  output logic                system_reset,
  output logic                running,
  output logic                done,
  output logic                pass,
  output logic                fail_trap,
  output logic                fail_timeout,
  output logic [CHW-1:0]      trap_channel,
  output logic [CCW-1:0]      cycle_count
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int DW = (TRAP_HOLDOFF > 0) ? $clog2(TRAP_HOLDOFF + 1) : 1;

  localparam logic [HW-1:0]  HOLD_LAST  = HW'(RESET_CYCLES - 1);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(TRAP_HOLDOFF);
  localparam logic [CCW-1:0] TMO_LAST   = CCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            trap_any;
  logic [CHW-1:0]  trap_idx;
  logic            sig_hit;
  logic            tmo_pass;

  // Descending scan so the lowest set index is the last one written
  always_comb begin
    trap_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (trap[i]) trap_idx = CHW'(i);
    end
  end

  assign trap_any = |trap;

`ifdef F8_RUN_SUPERVISOR_GPIO_PASS_EN
  localparam int SW = $clog2(PASS_STABLE + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(PASS_STABLE - 1);

  logic [SW-1:0] stab_cnt;
  logic          code_ok;

  assign code_ok  = (gpio0pins == PASS_CODE);
  assign sig_hit  = code_ok && (stab_cnt == STAB_LAST);
  assign tmo_pass = 1'b0;

  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      stab_cnt <= '0;
    end else if (state == RUN && code_ok) begin
      if (stab_cnt != STAB_LAST) stab_cnt <= stab_cnt + 1'b1;
    end else begin
      stab_cnt <= '0;
    end
  end
`else
  logic unused_gpio;

  assign unused_gpio = ^gpio0pins;
  assign sig_hit     = 1'b0;
  assign tmo_pass    = 1'b1;
`endif

  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      state        <= HOLD;
      system_reset <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_trap    <= 1'b0;
      fail_timeout <= 1'b0;
      trap_channel <= '0;
      cycle_count  <= '0;
      hold_cnt     <= '0;
      drain_cnt    <= '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state        <= RUN;
            system_reset <= 1'b0;
            running      <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (trap_any) begin
            state        <= DRAIN;
            running      <= 1'b0;
            fail_trap    <= 1'b1;
            trap_channel <= trap_idx;
          end else if (sig_hit) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b1;
          end else begin
            cycle_count <= cycle_count + 1'b1;
            if (cycle_count == TMO_LAST) begin
              state        <= DONE;
              running      <= 1'b0;
              done         <= 1'b1;
              pass         <= tmo_pass;
              fail_timeout <= !tmo_pass;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_f8_run_supervisor.sv
// Scoreboard bench for f8_run_supervisor (CHANNELS=4, default timings).
module tb_f8_run_supervisor;

  localparam int CH  = 4;
  localparam int TMO = 2045;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] trap;
  logic [7:0]    gpio;
  logic          system_reset;
  logic          running;
  logic          done;
  logic          pass;
  logic          fail_trap;
  logic          fail_timeout;
  logic [1:0]    trap_channel;
  logic [10:0]   cycle_count;

  always #5 clk = ~clk;

  f8_run_supervisor #(
    .CHANNELS       (CH),
    .RESET_CYCLES   (5),
    .TIMEOUT_CYCLES (TMO),
    .TRAP_HOLDOFF   (5),
    .PASS_CODE      (8'ha5),
    .PASS_STABLE    (4)
  ) dut (
    .clk              (clk),
    .power_on_reset_n (rst_n),
    .trap             (trap),
    .gpio0pins        (gpio),
    .system_reset     (system_reset),
    .running          (running),
    .done             (done),
    .pass             (pass),
    .fail_trap        (fail_trap),
    .fail_timeout     (fail_timeout),
    .trap_channel     (trap_channel),
    .cycle_count      (cycle_count)
  );

  typedef struct packed {
    logic        p;
    logic        ft;
    logic        fto;
    logic [1:0]  ch;
    logic [10:0] cc;
  } verdict_t;

  verdict_t sb[$];
  verdict_t exp_v;
  int       n_cmp = 0;
  int       n_bad = 0;
  logic     done_q = 1'b0;

  function automatic verdict_t mk(logic p, logic ft, logic fto,
                                  logic [1:0] ch, logic [10:0] cc);
    verdict_t v;
    v.p   = p;
    v.ft  = ft;
    v.fto = fto;
    v.ch  = ch;
    v.cc  = cc;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: each rising done pops one expected verdict
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 want no verdict");
      end else begin
        exp_v = sb.pop_front();
        chk("v_pass", pass, exp_v.p);
        chk("v_fail_trap", fail_trap, exp_v.ft);
        chk("v_fail_timeout", fail_timeout, exp_v.fto);
        chk("v_channel", trap_channel, exp_v.ch);
        chk("v_cycles", cycle_count, exp_v.cc);
      end
    end
    done_q = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input bit hold_trap);
    rst_n = 1'b0;
    trap  = '0;
    gpio  = 8'h00;
    #1;
    chk("rst_done", done, 0);
    chk("rst_sysrst", system_reset, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (hold_trap && i == 1) trap = 4'b0001;
      if (i == 3) trap = '0;
      if (i < 5) begin
        chk("hold_sysrst", system_reset, 1);
        chk("hold_running", running, 0);
      end else begin
        chk("run_sysrst", system_reset, 0);
        chk("run_running", running, 1);
        chk("run_cc0", cycle_count, 0);
        chk("run_no_trap", fail_trap, 0);
      end
    end
  endtask

  task automatic wait_count(input int target);
    int k = 0;
    while (int'(cycle_count) != target && k < 3000) begin
      tick();
      k++;
    end
    chk("reach_cc", cycle_count, target);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!done && k < bound) begin
      tick();
      k++;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    trap  = '0;
    gpio  = 8'h00;
    #12;
    chk("por_sysrst", system_reset, 1);
    chk("por_running", running, 0);
    chk("por_done", done, 0);
    chk("por_pass", pass, 0);
    chk("por_ft", fail_trap, 0);
    chk("por_fto", fail_timeout, 0);
    chk("por_cc", cycle_count, 0);
    chk("por_ch", trap_channel, 0);

    // Trap at RUN cycle 37, later trap on channel 3 ignored
    start_run(1'b1);
    wait_count(37);
    trap = 4'b0110;
    sb.push_back(mk(1'b0, 1'b1, 1'b0, 2'd1, 11'd37));
    tick();
    chk("trap_ft", fail_trap, 1);
    chk("trap_done0", done, 0);
    chk("trap_running", running, 0);
    chk("trap_cc", cycle_count, 37);
    trap = 4'b1000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("drain_done0", done, 0);
    end
    tick();
    chk("drain_done1", done, 1);
    trap = '0;
    @(negedge clk);
    #1;
    repeat (20) tick();
    chk("hold_ch", trap_channel, 1);
    chk("hold_cc", cycle_count, 37);
    chk("hold_pass", pass, 0);

    // Mid-run asynchronous reset
    start_run(1'b0);
    wait_count(500);
    rst_n = 1'b0;
    #2;
    chk("mid_sysrst", system_reset, 1);
    chk("mid_running", running, 0);
    chk("mid_done", done, 0);
    chk("mid_cc", cycle_count, 0);

    // Timeout
    start_run(1'b0);
`ifdef F8_RUN_SUPERVISOR_GPIO_PASS_EN
    sb.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, 11'd2045));
`else
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 11'd2045));
`endif
    wait_done(2100);
    chk("tmo_running", running, 0);
    repeat (100) tick();
    chk("tmo_hold_done", done, 1);
    chk("tmo_hold_cc", cycle_count, TMO);
`ifdef F8_RUN_SUPERVISOR_GPIO_PASS_EN
    chk("tmo_hold_fto", fail_timeout, 1);
`else
    chk("tmo_hold_pass", pass, 1);
`endif

    // Trap on the edge that would reach the timeout
    start_run(1'b0);
    wait_count(TMO - 1);
    trap = 4'b0100;
    sb.push_back(mk(1'b0, 1'b1, 1'b0, 2'd2, 11'd2044));
    tick();
    trap = '0;
    chk("tie_ft", fail_trap, 1);
    chk("tie_done0", done, 0);
    wait_done(20);
    chk("tie_pass", pass, 0);
    chk("tie_fto", fail_timeout, 0);

`ifdef F8_RUN_SUPERVISOR_GPIO_PASS_EN
    // Signature broken once, then four stable cycles
    start_run(1'b0);
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 11'd7));
    for (int i = 0; i < 8; i++) begin
      gpio = (i == 3) ? 8'h00 : 8'ha5;
      tick();
      if (i < 7) chk("sig_done0", done, 0);
      else chk("sig_done1", done, 1);
    end
    gpio = 8'h00;
    @(negedge clk);
    #1;
`endif

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
